// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data RAM among N_CORES cores.
// Each granted access takes three cycles: grant/latch, RAM strobe, then response with done.
module data_mem_arbiter #(
  parameter int N_CORES = 16,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [2*N_CORES-1:0]        ctrl_flat,
  input  logic [ADDR_W*N_CORES-1:0]   addr_flat,
  input  logic [DATA_W*N_CORES-1:0]   wdata_flat,
  output logic [N_CORES-1:0]          done,
  output logic [DATA_W-1:0]           rdata,
  output logic [N_CORES-1:0]          grant,
  output logic                        busy,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam logic [IDX_W:0] NC = (IDX_W+1)'(N_CORES);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_CORES - 1);
  localparam logic [N_CORES-1:0] ONE_HOT0 = {{(N_CORES-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic               r_op_wr;
  logic [N_CORES-1:0] r_done;
  logic [N_CORES-1:0] r_grant;
  logic [DATA_W-1:0]  r_rdata;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;

  logic [N_CORES-1:0] w_req;
  logic [1:0]         w_ctrl  [N_CORES];
  logic [ADDR_W-1:0]  w_addr  [N_CORES];
  logic [DATA_W-1:0]  w_wdata [N_CORES];
  logic               w_found;
  logic [IDX_W-1:0]   w_sel;

  // A core whose done pulse is visible this cycle is masked so it cannot be re-granted at once.
  for (genvar gi = 0; gi < N_CORES; gi++) begin : g_unpack
    assign w_ctrl[gi]  = ctrl_flat[2*gi +: 2];
    assign w_addr[gi]  = addr_flat[ADDR_W*gi +: ADDR_W];
    assign w_wdata[gi] = wdata_flat[DATA_W*gi +: DATA_W];
    assign w_req[gi]   = ((w_ctrl[gi] == 2'b01) || (w_ctrl[gi] == 2'b10)) && !r_done[gi];
  end

  // First requester searching upward from r_ptr+1, wrapping at N_CORES-1.
  always_comb begin
    logic [IDX_W:0] v_sum;
    w_found = 1'b0;
    w_sel   = '0;
    v_sum   = '0;
    for (int k = 1; k <= N_CORES; k++) begin
      v_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (v_sum >= NC) v_sum = v_sum - NC;
      if (!w_found && w_req[v_sum[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = v_sum[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= PTR_RST;
      r_idx       <= '0;
      r_op_wr     <= 1'b0;
      r_done      <= '0;
      r_grant     <= '0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_idx       <= w_sel;
            r_ptr       <= w_sel;
            r_op_wr     <= (w_ctrl[w_sel] == 2'b10);
            r_grant     <= ONE_HOT0 << w_sel;
            r_mem_addr  <= w_addr[w_sel];
            r_mem_wdata <= w_wdata[w_sel];
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: r_state <= S_RESP;
        S_RESP: begin
          if (!r_op_wr) r_rdata <= mem_rdata;
          r_done[r_idx] <= 1'b1;
          r_grant       <= '0;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done      = r_done;
  assign rdata     = r_rdata;
  assign grant     = r_grant;
  assign busy      = (r_state != S_IDLE);
  assign mem_en    = (r_state == S_ACCESS);
  assign mem_we    = mem_en && r_op_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Round-robin arbiter that shares one single-port synchronous data RAM between the 16 cores. Each core presents a 2-bit memory control code, an address and write data, then holds its request until it receives a done pulse. The arbiter serialises the accesses onto the RAM port and returns read data to the requesting core. It sits between the cores and the data RAM, replacing direct per-core port wiring.

Parameters:
N_CORES, 16, number of requesting cores
ADDR_W, 16, data address width
DATA_W, 16, data word width

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
ctrl_flat  in  2*N_CORES  per-core control; core i at [2i+1:2i]; 00 idle, 01 read, 10 write, 11 reserved (treated as idle)
addr_flat  in  ADDR_W*N_CORES  per-core address; core i at [ADDR_W*i +: ADDR_W]
wdata_flat  in  DATA_W*N_CORES  per-core write data, same packing
done  out  N_CORES  one-hot, one-cycle completion pulse to the served core
rdata  out  DATA_W  read data, broadcast to all cores; valid when the matching done bit is high
grant  out  N_CORES  one-hot index of the core currently being served; 0 when idle
busy  out  1  high when state is not IDLE
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable; only meaningful while mem_en is high
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data; valid one cycle after a read strobe

Behaviour:
- Reset values: state IDLE; done, grant, busy, mem_en and mem_we are 0; mem_addr, mem_wdata and rdata are 0; round-robin pointer is N_CORES-1, so core 0 has first priority.
- A core is requesting when its ctrl code is 01 or 10 and its done bit is 0 in the current cycle. This mask keeps a core from being re-granted in the cycle its done pulse is visible.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE with no requesters: stay in IDLE.
  - IDLE with at least one requester: select the first requester searching upward from pointer+1, wrapping at N_CORES-1 back to 0. Latch its index, op, address and write data. Set grant. Set the pointer to the selected index. Go to ACCESS.
  - ACCESS (exactly one cycle): mem_en=1, mem_we=(op==write), mem_addr and mem_wdata driven from the latched values. Go to RESP.
  - RESP (exactly one cycle): mem_en=0. On a read, capture mem_rdata into rdata; on a write, rdata holds its previous value. Register done[index]=1. Go to IDLE.
- Timing: a request sampled in IDLE at cycle t produces done and valid rdata at cycle t+3. The arbiter performs one access per 3 cycles. A new grant can be made in the same cycle a done pulse is visible.
- done is high for exactly one cycle. rdata holds its value until the next read completes.
- grant is cleared on entry to IDLE.
- Inputs from the served core are latched at grant. Changes to its ctrl, addr or wdata during ACCESS or RESP have no effect.
- A core that drops its request before being granted is simply skipped; no error is flagged.
- Reset asserted mid-operation aborts the transaction. Outputs take reset values on the next edge, and no done pulse is issued.
- Fairness: with all cores requesting continuously, each core is served exactly once per N_CORES grants.

Test Plan:
- Single read: memory word 0x0040 preloaded with 0xBEEF; core 3 drives ctrl=01, addr=0x0040 at cycle t. Required: mem_en at t+1 with mem_addr=0x0040 and mem_we=0; done[3]=1 and rdata=0xBEEF at t+3.
- Write then read: core 0 writes 0x1234 to 0x0010, then reads 0x0010. Required: mem_we=1 with mem_wdata=0x1234 during ACCESS; the following read returns rdata=0x1234.
- All 16 cores request at t after reset. Required: done order is core 0, 1, …, 15, at cycles t+3, t+6, …, t+48, with no gaps.
- Wrap-around: pointer at 14 (last grant was core 14); cores 2 and 15 request. Required: core 15 served first, then core 2.
- Reserved code: core 5 drives ctrl=11. Required: no grant and mem_en stays 0. Held request: core 7 holds ctrl=01 through its done. Required: core 7 is not re-granted in the done cycle.
- Reset mid-operation: reset asserted during ACCESS. Required: next cycle mem_en=0, grant=0, busy=0; no done pulse at any later cycle.
